// File: rtl/axis_burst_counter_ctrl.sv
// Emits counter words as framed AXIS bursts (length/gap/count); tvalid rises 1 cycle after start.
// Stalls hold tdata/tlast on tready=0; stop lets the current burst finish at its tlast.
module axis_burst_counter_ctrl #(
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int CNTR_WIDTH       = 32
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic                        cfg_start,
   input  logic                        cfg_stop,
   input  logic [CNTR_WIDTH-1:0]       cfg_length,
   input  logic [CNTR_WIDTH-1:0]       cfg_gap,
   input  logic [CNTR_WIDTH-1:0]       cfg_bursts,
   output logic                        sts_busy,
   output logic                        sts_done,
   output logic [CNTR_WIDTH-1:0]       sts_bursts,
   output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        m_axis_tlast
);

   typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

   localparam logic [CNTR_WIDTH-1:0]       C_ONE = CNTR_WIDTH'(1);
   localparam logic [AXIS_TDATA_WIDTH-1:0] D_ONE = AXIS_TDATA_WIDTH'(1);

   state_t                      state_q, state_d;
   logic [AXIS_TDATA_WIDTH-1:0] data_q, data_d;
   logic [CNTR_WIDTH-1:0]       beat_q, beat_d;
   logic [CNTR_WIDTH-1:0]       len_q, len_d;
   logic [CNTR_WIDTH-1:0]       gap_q, gap_d;
   logic [CNTR_WIDTH-1:0]       bursts_q, bursts_d;
   logic [CNTR_WIDTH-1:0]       gap_cnt_q, gap_cnt_d;
   logic [CNTR_WIDTH-1:0]       sts_bursts_q, sts_bursts_d;
   logic                        stop_pend_q, stop_pend_d;
   logic                        tvalid_q, tvalid_d;
   logic                        tlast_q, tlast_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;
   logic [CNTR_WIDTH-1:0]       beat_inc;
   logic [CNTR_WIDTH-1:0]       sts_inc;

   always_comb begin
      state_d      = state_q;
      data_d       = data_q;
      beat_d       = beat_q;
      len_d        = len_q;
      gap_d        = gap_q;
      bursts_d     = bursts_q;
      gap_cnt_d    = gap_cnt_q;
      sts_bursts_d = sts_bursts_q;
      stop_pend_d  = stop_pend_q;
      tvalid_d     = tvalid_q;
      tlast_d      = tlast_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      beat_inc     = beat_q + C_ONE;
      sts_inc      = sts_bursts_q + C_ONE;

      case (state_q)
         S_IDLE: begin
            if (cfg_start && !cfg_stop && cfg_length != '0) begin
               state_d      = S_BURST;
               len_d        = cfg_length;
               gap_d        = cfg_gap;
               bursts_d     = cfg_bursts;
               data_d       = '0;
               beat_d       = '0;
               sts_bursts_d = '0;
               tvalid_d     = 1'b1;
               tlast_d      = (cfg_length == C_ONE);
               busy_d       = 1'b1;
            end
         end
         S_BURST: begin
            if (cfg_stop) stop_pend_d = 1'b1;
            // tvalid is always high here, so tready alone completes the beat
            if (m_axis_tready) begin
               data_d = data_q + D_ONE;
               if (tlast_q) begin
                  sts_bursts_d = sts_inc;
                  beat_d       = '0;
                  if ((bursts_q != '0 && sts_inc == bursts_q) || stop_pend_q || cfg_stop) begin
                     state_d     = S_IDLE;
                     tvalid_d    = 1'b0;
                     tlast_d     = 1'b0;
                     busy_d      = 1'b0;
                     done_d      = 1'b1;
                     stop_pend_d = 1'b0;
                  end else if (gap_q == '0) begin
                     tlast_d = (len_q == C_ONE);
                  end else begin
                     state_d   = S_GAP;
                     tvalid_d  = 1'b0;
                     tlast_d   = 1'b0;
                     gap_cnt_d = gap_q;
                  end
               end else begin
                  beat_d  = beat_inc;
                  tlast_d = (beat_inc == len_q - C_ONE);
               end
            end
         end
         S_GAP: begin
            if (cfg_stop) begin
               state_d     = S_IDLE;
               busy_d      = 1'b0;
               done_d      = 1'b1;
               stop_pend_d = 1'b0;
            end else if (gap_cnt_q == C_ONE) begin
               state_d  = S_BURST;
               tvalid_d = 1'b1;
               tlast_d  = (len_q == C_ONE);
               beat_d   = '0;
            end else begin
               gap_cnt_d = gap_cnt_q - C_ONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= S_IDLE;
         data_q       <= '0;
         beat_q       <= '0;
         len_q        <= '0;
         gap_q        <= '0;
         bursts_q     <= '0;
         gap_cnt_q    <= '0;
         sts_bursts_q <= '0;
         stop_pend_q  <= 1'b0;
         tvalid_q     <= 1'b0;
         tlast_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         data_q       <= data_d;
         beat_q       <= beat_d;
         len_q        <= len_d;
         gap_q        <= gap_d;
         bursts_q     <= bursts_d;
         gap_cnt_q    <= gap_cnt_d;
         sts_bursts_q <= sts_bursts_d;
         stop_pend_q  <= stop_pend_d;
         tvalid_q     <= tvalid_d;
         tlast_q      <= tlast_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign sts_busy      = busy_q;
   assign sts_done      = done_q;
   assign sts_bursts    = sts_bursts_q;
   assign m_axis_tdata  = data_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_axis_burst_counter_ctrl.sv
// Bench for axis_burst_counter_ctrl: expected beats and valid timelines are built from burst arithmetic.
module tb_axis_burst_counter_ctrl;
   localparam int TW = 4;
   localparam int CW = 32;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          cfg_start = 1'b0;
   logic          cfg_stop = 1'b0;
   logic [CW-1:0] cfg_length = '0;
   logic [CW-1:0] cfg_gap = '0;
   logic [CW-1:0] cfg_bursts = '0;
   logic          sts_busy;
   logic          sts_done;
   logic [CW-1:0] sts_bursts;
   logic [TW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b0;
   logic          m_axis_tlast;

   axis_burst_counter_ctrl #(.AXIS_TDATA_WIDTH(TW), .CNTR_WIDTH(CW)) dut (
      .aclk(aclk), .aresetn(aresetn), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
      .cfg_length(cfg_length), .cfg_gap(cfg_gap), .cfg_bursts(cfg_bursts),
      .sts_busy(sts_busy), .sts_done(sts_done), .sts_bursts(sts_bursts),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int fails  = 0;

   int  exp_d[$];
   bit  exp_l[$];
   bit  exp_v[$];
   int  obs_d[$];
   bit  obs_l[$];
   bit  vld_h[$];
   bit  done_h[$];
   bit  busy_h[$];
   int  stall_viol, done_cnt, cyc, rdy_mode, stop_at;
   bit  stop_armed, stalled, timed_out;
   int  held_d;
   bit  held_l;
   bit  pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   task automatic clear_trace();
      exp_d.delete(); exp_l.delete(); exp_v.delete();
      obs_d.delete(); obs_l.delete();
      vld_h.delete(); done_h.delete(); busy_h.delete();
      stall_viol = 0; done_cnt = 0; cyc = 0; stop_at = -1;
      stop_armed = 0; stalled = 0; timed_out = 0;
   endtask

   // One clock cycle: choose tready, observe outputs, advance past the edge.
   task automatic cycle();
      case (rdy_mode)
         1:       m_axis_tready = ($urandom_range(0, 2) != 0);
         2:       m_axis_tready = pat[cyc % 6];
         default: m_axis_tready = 1'b1;
      endcase
      if (stop_at >= 0 && !stop_armed && m_axis_tvalid && int'(m_axis_tdata) == stop_at) begin
         cfg_stop   = 1'b1;
         stop_armed = 1;
      end
      if (stalled && (!m_axis_tvalid || int'(m_axis_tdata) != held_d || m_axis_tlast != held_l))
         stall_viol++;
      stalled = m_axis_tvalid && !m_axis_tready;
      held_d  = int'(m_axis_tdata);
      held_l  = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
         obs_d.push_back(int'(m_axis_tdata));
         obs_l.push_back(m_axis_tlast);
      end
      vld_h.push_back(m_axis_tvalid);
      done_h.push_back(sts_done);
      busy_h.push_back(sts_busy);
      if (sts_done) done_cnt++;
      @(posedge aclk);
      #1;
      cfg_start = 1'b0;
      cfg_stop  = 1'b0;
      cyc++;
   endtask

   task automatic run_to_idle(input int maxc);
      int n = 0;
      cycle();
      while (sts_busy && n < maxc) begin
         cycle();
         n++;
      end
      timed_out = sts_busy;
      cycle();
   endtask

   task automatic start(input int len, input int gap, input int nb);
      cfg_length = CW'(len);
      cfg_gap    = CW'(gap);
      cfg_bursts = CW'(nb);
      cfg_start  = 1'b1;
   endtask

   // Expected stream: burst b, word i carries (base + b*len + i) mod 2^TW; tlast on i = len-1.
   task automatic build_exp(input int len, input int nb, input int base);
      for (int b = 0; b < nb; b++)
         for (int i = 0; i < len; i++) begin
            exp_d.push_back((base + b * len + i) % (1 << TW));
            exp_l.push_back(i == len - 1);
         end
   endtask

   // Expected tvalid timeline with tready held high: start cycle, bursts separated by gaps, done cycle.
   task automatic build_vld(input int len, input int gap, input int nb);
      exp_v.push_back(1'b0);
      for (int b = 0; b < nb; b++) begin
         for (int i = 0; i < len; i++) exp_v.push_back(1'b1);
         if (b < nb - 1)
            for (int g = 0; g < gap; g++) exp_v.push_back(1'b0);
      end
      exp_v.push_back(1'b0);
   endtask

   task automatic test_reset();
      checks++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
      checks++; if (m_axis_tlast !== 1'b0) begin fails++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
      checks++; if (m_axis_tdata !== '0) begin fails++; $display("FAIL reset_tdata: got %0d want 0", m_axis_tdata); end
      checks++; if (sts_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", sts_busy); end
      checks++; if (sts_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", sts_done); end
      checks++; if (sts_bursts !== '0) begin fails++; $display("FAIL reset_bursts: got %0d want 0", sts_bursts); end
   endtask

   task automatic test_back_to_back();
      clear_trace(); rdy_mode = 0;
      build_exp(4, 2, 0); build_vld(4, 0, 2);
      start(4, 0, 2);
      run_to_idle(100);
      checks++; if (timed_out) begin fails++; $display("FAIL b2b_timeout: busy still %b want 0", sts_busy); end
      checks++; if (obs_d.size() != exp_d.size()) begin fails++; $display("FAIL b2b_count: got %0d want %0d", obs_d.size(), exp_d.size()); end
      for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
         checks++;
         if (obs_d[i] != exp_d[i] || obs_l[i] != exp_l[i]) begin
            fails++; $display("FAIL b2b_beat%0d: got %0d/%b want %0d/%b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
         end
      end
      for (int i = 0; i < exp_v.size() && i < vld_h.size(); i++) begin
         checks++;
         if (vld_h[i] != exp_v[i]) begin fails++; $display("FAIL b2b_vld_cyc%0d: got %b want %b", i, vld_h[i], exp_v[i]); end
      end
      checks++; if (done_h.size() < 10 || done_h[9] != 1'b1) begin fails++; $display("FAIL b2b_done_cyc9: got none want 1"); end
      checks++; if (busy_h.size() < 10 || busy_h[9] != 1'b0) begin fails++; $display("FAIL b2b_busy_cyc9: got 1 want 0"); end
      checks++; if (done_cnt != 1) begin fails++; $display("FAIL b2b_done_cnt: got %0d want 1", done_cnt); end
      checks++; if (sts_bursts !== CW'(2)) begin fails++; $display("FAIL b2b_sts_bursts: got %0d want 2", sts_bursts); end
   endtask

   task automatic test_gap();
      clear_trace(); rdy_mode = 0;
      build_exp(3, 2, 0); build_vld(3, 2, 2);
      start(3, 2, 2);
      run_to_idle(100);
      checks++; if (vld_h.size() != exp_v.size()) begin fails++; $display("FAIL gap_len: got %0d cycles want %0d", vld_h.size(), exp_v.size()); end
      for (int i = 0; i < exp_v.size() && i < vld_h.size(); i++) begin
         checks++;
         if (vld_h[i] != exp_v[i]) begin fails++; $display("FAIL gap_vld_cyc%0d: got %b want %b", i, vld_h[i], exp_v[i]); end
      end
      for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
         checks++;
         if (obs_d[i] != exp_d[i] || obs_l[i] != exp_l[i]) begin
            fails++; $display("FAIL gap_beat%0d: got %0d/%b want %0d/%b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
         end
      end
      checks++; if (done_cnt != 1) begin fails++; $display("FAIL gap_done_cnt: got %0d want 1", done_cnt); end
      checks++; if (done_h[done_h.size() - 1] != 1'b1) begin fails++; $display("FAIL gap_done_cyc: got 0 want 1"); end
   endtask

   task automatic test_random_bursts();
      for (int it = 0; it < 6; it++) begin
         int len = $urandom_range(1, 6);
         int gap = $urandom_range(0, 3);
         int nb  = $urandom_range(1, 3);
         clear_trace(); rdy_mode = 1;
         build_exp(len, nb, 0);
         start(len, gap, nb);
         run_to_idle(500);
         checks++; if (timed_out) begin fails++; $display("FAIL rnd%0d_timeout: busy %b want 0", it, sts_busy); end
         checks++; if (obs_d.size() != exp_d.size()) begin fails++; $display("FAIL rnd%0d_count: got %0d want %0d", it, obs_d.size(), exp_d.size()); end
         for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            checks++;
            if (obs_d[i] != exp_d[i] || obs_l[i] != exp_l[i]) begin
               fails++; $display("FAIL rnd%0d_beat%0d: got %0d/%b want %0d/%b", it, i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
            end
         end
         checks++; if (stall_viol != 0) begin fails++; $display("FAIL rnd%0d_stall: got %0d unstable stalls want 0", it, stall_viol); end
         checks++; if (done_cnt != 1) begin fails++; $display("FAIL rnd%0d_done: got %0d want 1", it, done_cnt); end
         checks++; if (sts_bursts !== CW'(nb)) begin fails++; $display("FAIL rnd%0d_bursts: got %0d want %0d", it, sts_bursts, nb); end
      end
   endtask

   task automatic test_stall();
      clear_trace(); rdy_mode = 2;
      build_exp(4, 1, 0);
      start(4, 0, 1);
      run_to_idle(100);
      checks++; if (obs_d.size() != 4) begin fails++; $display("FAIL stall_count: got %0d want 4", obs_d.size()); end
      for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
         checks++;
         if (obs_d[i] != exp_d[i] || obs_l[i] != exp_l[i]) begin
            fails++; $display("FAIL stall_beat%0d: got %0d/%b want %0d/%b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
         end
      end
      checks++; if (stall_viol != 0) begin fails++; $display("FAIL stall_stable: got %0d unstable stalls want 0", stall_viol); end
      checks++; if (done_cnt != 1) begin fails++; $display("FAIL stall_done: got %0d want 1", done_cnt); end
   endtask

   task automatic test_stop();
      int n;
      clear_trace(); rdy_mode = 0; stop_at = 7;
      build_exp(5, 2, 0);
      start(5, 0, 0);
      run_to_idle(100);
      checks++; if (obs_d.size() != exp_d.size()) begin fails++; $display("FAIL stop_count: got %0d want %0d", obs_d.size(), exp_d.size()); end
      for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
         checks++;
         if (obs_d[i] != exp_d[i] || obs_l[i] != exp_l[i]) begin
            fails++; $display("FAIL stop_beat%0d: got %0d/%b want %0d/%b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
         end
      end
      checks++; if (done_cnt != 1) begin fails++; $display("FAIL stop_done: got %0d want 1", done_cnt); end
      checks++; if (sts_bursts !== CW'(2)) begin fails++; $display("FAIL stop_bursts: got %0d want 2", sts_bursts); end

      clear_trace(); rdy_mode = 0;
      start(3, 4, 0);
      n = 0;
      cycle();
      while (obs_d.size() < 3 && n < 50) begin cycle(); n++; end
      checks++; if (obs_d.size() != 3) begin fails++; $display("FAIL gapstop_first_burst: got %0d beats want 3", obs_d.size()); end
      cycle();
      checks++; if (m_axis_tvalid !== 1'b0 || sts_busy !== 1'b1) begin fails++; $display("FAIL gapstop_in_gap: got vld %b busy %b want 0 1", m_axis_tvalid, sts_busy); end
      cfg_stop = 1'b1;
      cycle();
      checks++; if (sts_busy !== 1'b0) begin fails++; $display("FAIL gapstop_busy: got %b want 0", sts_busy); end
      checks++; if (sts_done !== 1'b1) begin fails++; $display("FAIL gapstop_done: got %b want 1", sts_done); end
      checks++; if (sts_bursts !== CW'(1)) begin fails++; $display("FAIL gapstop_bursts: got %0d want 1", sts_bursts); end
      repeat (6) cycle();
      checks++; if (obs_d.size() != 3 || done_cnt != 1) begin fails++; $display("FAIL gapstop_quiet: got %0d beats %0d dones want 3 1", obs_d.size(), done_cnt); end
   endtask

   task automatic test_edge_cases();
      clear_trace(); rdy_mode = 0;
      start(0, 0, 3);
      repeat (5) cycle();
      cfg_stop = 1'b1;
      start(4, 0, 1);
      repeat (5) cycle();
      checks++; if (obs_d.size() != 0) begin fails++; $display("FAIL edge_no_beats: got %0d want 0", obs_d.size()); end
      checks++; if (done_cnt != 0) begin fails++; $display("FAIL edge_no_done: got %0d want 0", done_cnt); end
      checks++; if (busy_h.sum() with (int'(item)) != 0) begin fails++; $display("FAIL edge_no_busy: busy seen want never"); end
      checks++; if (sts_bursts !== CW'(1)) begin fails++; $display("FAIL edge_bursts_hold: got %0d want 1", sts_bursts); end

      clear_trace(); rdy_mode = 0;
      build_exp(4, 2, 0); build_vld(4, 1, 2);
      start(4, 1, 2);
      cycle(); cycle();
      start(7, 0, 5);
      cycle();
      cfg_length = CW'(2); cfg_gap = CW'(3); cfg_bursts = CW'(9);
      run_to_idle(100);
      checks++; if (obs_d.size() != exp_d.size()) begin fails++; $display("FAIL busy_start_count: got %0d want %0d", obs_d.size(), exp_d.size()); end
      for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
         checks++;
         if (obs_d[i] != exp_d[i] || obs_l[i] != exp_l[i]) begin
            fails++; $display("FAIL busy_start_beat%0d: got %0d/%b want %0d/%b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
         end
      end
      for (int i = 0; i < exp_v.size() && i < vld_h.size(); i++) begin
         checks++;
         if (vld_h[i] != exp_v[i]) begin fails++; $display("FAIL busy_start_vld_cyc%0d: got %b want %b", i, vld_h[i], exp_v[i]); end
      end
      checks++; if (done_cnt != 1) begin fails++; $display("FAIL busy_start_done: got %0d want 1", done_cnt); end
   endtask

   task automatic test_wrap();
      clear_trace(); rdy_mode = 1;
      build_exp(20, 1, 0);
      start(20, 0, 1);
      run_to_idle(500);
      checks++; if (obs_d.size() != 20) begin fails++; $display("FAIL wrap_count: got %0d want 20", obs_d.size()); end
      for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
         checks++;
         if (obs_d[i] != exp_d[i] || obs_l[i] != exp_l[i]) begin
            fails++; $display("FAIL wrap_beat%0d: got %0d/%b want %0d/%b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
         end
      end
      checks++; if (obs_d.size() < 17 || obs_d[15] != 15 || obs_d[16] != 0) begin fails++; $display("FAIL wrap_edge: 15->0 transition not seen"); end
   endtask

   task automatic test_reset_mid();
      clear_trace(); rdy_mode = 0;
      start(2, 0, 0);
      repeat (6) cycle();
      checks++; if (sts_bursts !== CW'(2) || m_axis_tvalid !== 1'b1) begin fails++; $display("FAIL rstmid_pre: got bursts %0d vld %b want 2 1", sts_bursts, m_axis_tvalid); end
      #2 aresetn = 1'b0;
      #1;
      checks++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL rstmid_tvalid: got %b want 0", m_axis_tvalid); end
      checks++; if (sts_busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", sts_busy); end
      checks++; if (sts_bursts !== '0) begin fails++; $display("FAIL rstmid_bursts: got %0d want 0", sts_bursts); end
      checks++; if (m_axis_tdata !== '0) begin fails++; $display("FAIL rstmid_tdata: got %0d want 0", m_axis_tdata); end
      @(posedge aclk); #1;
      aresetn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rdy_mode = 0;
      repeat (3) @(posedge aclk);
      #1;
      test_reset();
      aresetn = 1'b1;
      @(posedge aclk); #1;
      test_back_to_back();
      test_gap();
      test_random_bursts();
      test_stall();
      test_stop();
      test_edge_cases();
      test_wrap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
